dc_fifo_st_reader: RTL
======================

// Module: dc_fifo_st_reader
// PURPOSE
//  Read-side drain for a show-ahead dual-clock FIFO whose words carry packet framing.
//  Pops words from the FIFO read port and presents them as an Avalon-ST source (readyLatency 0) with registered outputs.
//  Enforces SOP/EOP framing: drops orphan words between packets and flags truncated packets.
//  Sits in the FIFO read clock domain; clk is the FIFO rdclk.
// PARAMETERS
//  DATA_WIDTH   64  payload width per beat
//  EMPTY_WIDTH  3   width of empty-symbol field, valid on EOP beat only
//  CNT_WIDTH    16  width of each saturating statistics counter
//  FIFO word W = DATA_WIDTH+EMPTY_WIDTH+2, packed as {sop, eop, empty, data}, MSB first
// PORTS
//  clk              in   1            clock (= FIFO rdclk)
//  rst_n            in   1            asynchronous reset, active low
//  fifo_q           in   W            FIFO show-ahead head word; valid when !fifo_rdempty
//  fifo_rdempty     in   1            FIFO empty
//  fifo_rdreq       out  1            pop head word (combinational)
//  out_valid        out  1            stream beat valid
//  out_ready        in   1            sink ready
//  out_data         out  DATA_WIDTH   beat payload
//  out_sop          out  1            start of packet
//  out_eop          out  1            end of packet
//  out_empty        out  EMPTY_WIDTH  empty symbols; forced 0 when !out_eop
//  out_error        out  1            beat is a SOP arriving inside an open packet (previous packet truncated)
//  clr_cnt          in   1            synchronous clear of all counters
//  pkt_cnt          out  CNT_WIDTH    packets delivered (EOP beats accepted by sink)
//  orphan_cnt       out  CNT_WIDTH    words dropped in IDLE without SOP
//  framing_err_cnt  out  CNT_WIDTH    SOP seen while IN_PKT
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid, out_sop, out_eop, out_error = 0; out_data, out_empty = 0; state IDLE; all counters 0.
//  fifo_rdreq forced 0 while rst_n is low.
//  head = !fifo_rdempty; drop = head && state==IDLE && !fifo_q.sop.
//  load = head && !drop && (!out_valid || out_ready); fifo_rdreq = drop || load.
//  Drops never wait on out_ready. Throughput is 1 beat/cycle.
//  Latency: a word at the head with a free or draining output stage appears on out_* the next cycle.
//  Handshake: a beat transfers when out_valid && out_ready. While out_valid && !out_ready, all out_* hold stable.
//  If no load occurs, out_valid falls after a transfer.
//  FSM:
//   IDLE:   SOP word -> load; eop=1 -> stay IDLE, else -> IN_PKT.
//           non-SOP word -> drop, orphan_cnt+1.
//   IN_PKT: every word loaded. eop=1 -> IDLE.
//           SOP word -> load with out_error=1, framing_err_cnt+1; next state IN_PKT, or IDLE if eop also set.
//  The state advances on load/drop (pop time), not on sink transfer.
//  pkt_cnt+1 on the cycle an out_eop beat transfers.
//  Counters saturate at all-ones. clr_cnt wins over a simultaneous increment (result 0).
//  Reset mid-packet: in-flight output beat discarded. The FSM restarts in IDLE, so the packet remainder is dropped as orphans.
// TESTING
//  1. 3-beat pkt (sop / - / eop, empty=5), out_ready=1 -> rdreq on 3 consecutive cycles; out beats sop,-,eop.
//     out_empty=5 on last beat only; pkt_cnt=1.
//  2. FIFO holds 4 words, out_ready=0 for 5 cycles after first load -> rdreq=0, out_data stable.
//     Then out_ready=1 -> 4 beats on back-to-back cycles, none lost or duplicated.
//  3. IDLE, 2 words without sop, then sop+eop word -> 2 pops with out_valid=0; orphan_cnt=2; one beat out (sop=eop=1); pkt_cnt=1.
//  4. sop, mid, sop+eop -> third beat out_error=1; framing_err_cnt=1; FSM ends in IDLE; pkt_cnt=1.
//  5. rst_n low after 2nd beat of a 4-beat pkt -> out_valid=0 immediately, counters 0.
//     After release: beats 3-4 dropped, orphan_cnt=2.
//  6. CNT_WIDTH=2: 5 orphans -> orphan_cnt=3 (saturated). clr_cnt together with 6th orphan -> orphan_cnt=0.

Source files
------------

// File: rtl/dc_fifo_st_reader.sv
// Show-ahead FIFO drain to Avalon-ST source with SOP/EOP framing checks; 1-cycle pop-to-output latency.
// Registered output stage stalls the pop while out_valid && !out_ready; orphan drops ignore backpressure.
module dc_fifo_st_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH+EMPTY_WIDTH+1:0]     fifo_q,
    input  logic                                  fifo_rdempty,
    output logic                                  fifo_rdreq,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_sop,
    output logic                                  out_eop,
    output logic [EMPTY_WIDTH-1:0]                out_empty,
    output logic                                  out_error,
    input  logic                                  clr_cnt,
    output logic [CNT_WIDTH-1:0]                  pkt_cnt,
    output logic [CNT_WIDTH-1:0]                  orphan_cnt,
    output logic [CNT_WIDTH-1:0]                  framing_err_cnt
);

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [DATA_WIDTH-1:0]  data;
    } word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    word_t  head_w;
    state_t state_q, state_d;
    logic   head, drop, load, xfer, frame_err;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [EMPTY_WIDTH-1:0] out_empty_q, out_empty_d;
    logic                   out_error_q, out_error_d;

    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] orphan_cnt_q, orphan_cnt_d;
    logic [CNT_WIDTH-1:0] ferr_cnt_q, ferr_cnt_d;

    assign head_w    = word_t'(fifo_q);
    assign head      = !fifo_rdempty;
    assign drop      = head && (state_q == IDLE) && !head_w.sop;
    assign load      = head && !drop && (!out_valid_q || out_ready);
    assign xfer      = out_valid_q && out_ready;
    assign frame_err = load && (state_q == IN_PKT) && head_w.sop;

    // Gate with rst_n so nothing is popped while the block is held in reset.
    assign fifo_rdreq = rst_n && (drop || load);

    // Framing state tracks what has been popped, not what the sink has taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = head_w.eop ? IDLE : IN_PKT;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_error_d = out_error_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head_w.data;
            out_sop_d   = head_w.sop;
            out_eop_d   = head_w.eop;
            out_empty_d = head_w.eop ? head_w.empty : '0;
            out_error_d = frame_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_error_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_error_q <= out_error_d;
        end
    end

    // Saturating increment; a clear in the same cycle takes priority.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
            nxt = cur + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    always_comb begin
        pkt_cnt_d    = cnt_next(pkt_cnt_q, xfer && out_eop_q, clr_cnt);
        orphan_cnt_d = cnt_next(orphan_cnt_q, drop, clr_cnt);
        ferr_cnt_d   = cnt_next(ferr_cnt_q, frame_err, clr_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q    <= '0;
            orphan_cnt_q <= '0;
            ferr_cnt_q   <= '0;
        end else begin
            pkt_cnt_q    <= pkt_cnt_d;
            orphan_cnt_q <= orphan_cnt_d;
            ferr_cnt_q   <= ferr_cnt_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_sop         = out_sop_q;
    assign out_eop         = out_eop_q;
    assign out_empty       = out_empty_q;
    assign out_error       = out_error_q;
    assign pkt_cnt         = pkt_cnt_q;
    assign orphan_cnt      = orphan_cnt_q;
    assign framing_err_cnt = ferr_cnt_q;

endmodule
